seq_shift_unit: RTL and testbench

//  Multi-cycle, parametrised shifter: next generation of the fixed shift-left-2 branch/jump

---
 rtl/seq_shift_unit_if.sv | 28 ++
 rtl/seq_shift_unit.sv | 112 +++++++++++
 tb/tb_seq_shift_unit.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_unit_if.sv
// Handshake bundle between a shifter client (master) and seq_shift_unit (slave).
`default_nettype none

interface seq_shift_unit_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
  logic               start;
  logic [1:0]         op;
  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   data_in;
  logic               abort;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;

  modport master (
    output start, op, shamt, data_in, abort,
    input  busy, done, result
  );

  modport slave (
    input  start, op, shamt, data_in, abort,
    output busy, done, result
  );
endinterface

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// Multi-cycle SLL/SRL/SRA/ROTR shifter, up to STEP bit positions per cycle, start/done handshake.
`default_nettype none

module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input wire logic        clk,
    input wire logic        reset_n,
    seq_shift_unit_if.slave bus
);

  localparam logic [1:0] c_S_IDLE  = 2'd0;
  localparam logic [1:0] c_S_SHIFT = 2'd1;
  localparam logic [1:0] c_S_DONE  = 2'd2;

  localparam logic [1:0] c_OP_SLL  = 2'd0;
  localparam logic [1:0] c_OP_SRL  = 2'd1;
  localparam logic [1:0] c_OP_SRA  = 2'd2;
  localparam logic [1:0] c_OP_ROTR = 2'd3;

  localparam logic [SHAMT_W:0] c_STEP  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] c_WIDTH = (SHAMT_W+1)'(WIDTH);

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [1:0]         op_q, op_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W:0]   w_k;
  logic [WIDTH-1:0]   w_shifted;

  // One step of the selected mode by k = min(remaining, STEP) positions.
  // SRA keeps the MSB in place, so it always equals the captured sign bit.
  always_comb begin
    w_k = ({1'b0, rem_q} < c_STEP) ? {1'b0, rem_q} : c_STEP;
    w_shifted = work_q;
    case (op_q)
      c_OP_SLL:  w_shifted = work_q << w_k;
      c_OP_SRL:  w_shifted = work_q >> w_k;
      c_OP_SRA:  w_shifted = $signed(work_q) >>> w_k;
      c_OP_ROTR: w_shifted = (work_q >> w_k) | (work_q << (c_WIDTH - w_k));
      default:   w_shifted = work_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= c_S_IDLE;
      work_q  <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    op_d    = op_q;
    rem_d   = rem_q;
    case (state_q)
      c_S_IDLE, c_S_DONE: begin
        if (bus.start) begin
          work_d  = bus.data_in;
          op_d    = bus.op;
          rem_d   = bus.shamt;
          state_d = (bus.shamt == '0) ? c_S_DONE : c_S_SHIFT;
        end else begin
          state_d = c_S_IDLE;
        end
      end
      c_S_SHIFT: begin
        // Abort wins over start here; start is never looked at while shifting.
        if (bus.abort) begin
          state_d = c_S_IDLE;
        end else begin
          work_d = w_shifted;
          rem_d  = rem_q - w_k[SHAMT_W-1:0];
          if (rem_q == w_k[SHAMT_W-1:0]) begin
            state_d = c_S_DONE;
          end
        end
      end
      default: state_d = c_S_IDLE;
    endcase
  end

  // Status flags are registered from the next state so they line up with state_q.
  always_comb begin
    busy_d = (state_d == c_S_SHIFT);
    done_d = (state_d == c_S_DONE);
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = work_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// Scoreboard bench: STEP=1 and STEP=8 shifters checked against an arithmetic reference model.
`default_nettype none

module tb_seq_shift_unit;

  typedef struct {
    logic [31:0] res;
    int          cyc;
    int          busy;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   bcnt1 = 0;
  int   bcnt8 = 0;
  exp_t q1[$];
  exp_t q8[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) b1 ();
  seq_shift_unit_if #(.WIDTH(32), .SHAMT_W(5)) b8 ();

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(b1.slave)
  );
  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .bus(b8.slave)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input int sh, input logic [31:0] d);
    logic [63:0] t;
    case (op)
      2'd0:    t = {32'd0, d} << sh;
      2'd1:    t = {32'd0, d} >> sh;
      2'd2:    t = {{32{d[31]}}, d} >> sh;
      default: t = {d, d} >> sh;
    endcase
    return t[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (b1.done) begin
        if (q1.size() == 0) begin
          total++; bad++;
          $display("FAIL done1_unexpected: got done=1 want done=0 (t=%0t)", $time);
        end else begin
          e = q1.pop_front();
          chk("result1", b1.result, e.res);
          chk("latency1", 32'(cyc), 32'(e.cyc));
          chk("busy_cycles1", 32'(bcnt1), 32'(e.busy));
        end
        bcnt1 = 0;
      end else if (b1.busy) bcnt1++;
      else bcnt1 = 0;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (b8.done) begin
        if (q8.size() == 0) begin
          total++; bad++;
          $display("FAIL done8_unexpected: got done=1 want done=0 (t=%0t)", $time);
        end else begin
          e = q8.pop_front();
          chk("result8", b8.result, e.res);
          chk("latency8", 32'(cyc), 32'(e.cyc));
          chk("busy_cycles8", 32'(bcnt8), 32'(e.busy));
        end
        bcnt8 = 0;
      end else if (b8.busy) bcnt8++;
      else bcnt8 = 0;
    end
  end

  // Called just after a negedge; leaves the bench one negedge later with start low.
  task automatic start_op(input bit e1, input bit e8, input logic [1:0] op, input int sh,
                          input logic [31:0] d, input bit push);
    int n8;
    n8 = (sh + 7) / 8;
    if (e1) begin
      b1.start = 1'b1; b1.op = op; b1.shamt = 5'(sh); b1.data_in = d;
      if (push) q1.push_back('{ref_shift(op, sh, d), cyc + 1 + sh, sh});
    end
    if (e8) begin
      b8.start = 1'b1; b8.op = op; b8.shamt = 5'(sh); b8.data_in = d;
      if (push) q8.push_back('{ref_shift(op, sh, d), cyc + 1 + n8, n8});
    end
    @(negedge clk);
    b1.start = 1'b0; b8.start = 1'b0;
    b1.op = 2'($urandom); b1.shamt = 5'($urandom); b1.data_in = $urandom;
    b8.op = 2'($urandom); b8.shamt = 5'($urandom); b8.data_in = $urandom;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && (q1.size() != 0 || q8.size() != 0); i++) @(negedge clk);
    if (q1.size() != 0 || q8.size() != 0) begin
      total++; bad++;
      $display("FAIL done_timeout: got pending=%0d want pending=0", q1.size() + q8.size());
      q1.delete(); q8.delete();
    end
  endtask

  initial begin
    b1.start = 0; b1.op = 0; b1.shamt = 0; b1.data_in = 0; b1.abort = 0;
    b8.start = 0; b8.op = 0; b8.shamt = 0; b8.data_in = 0; b8.abort = 0;
    #1;
    chk("rst_busy1", 32'(b1.busy), 0);   chk("rst_done1", 32'(b1.done), 0);
    chk("rst_result1", b1.result, 0);    chk("rst_busy8", 32'(b8.busy), 0);
    chk("rst_done8", 32'(b8.done), 0);   chk("rst_result8", b8.result, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    start_op(1, 1, 2'd0, 2, 32'h0000_0001, 1);  drain();
    start_op(1, 1, 2'd2, 31, 32'h8000_0000, 1); drain();
    start_op(1, 1, 2'd3, 4, 32'h0000_000F, 1);  drain();
    start_op(1, 1, 2'd1, 4, 32'h0000_000F, 1);  drain();
    for (int o = 0; o < 4; o++) begin
      start_op(1, 1, 2'(o), 0, 32'hDEAD_BEEF, 1); drain();
    end

    // A second start while busy must be ignored.
    start_op(1, 1, 2'd1, 20, 32'hFF00_0000, 1);
    b1.start = 1; b1.op = 2'd0; b1.shamt = 5'd1; b1.data_in = 32'h1234_5678;
    b8.start = 1; b8.op = 2'd0; b8.shamt = 5'd1; b8.data_in = 32'h1234_5678;
    @(negedge clk);
    b1.start = 0; b8.start = 0;
    drain();

    // Back-to-back: new start issued in the cycle done is high.
    start_op(1, 0, 2'd0, 3, 32'hA5A5_0F0F, 1);
    for (int i = 0; i < 100 && !b1.done; i++) @(negedge clk);
    start_op(1, 0, 2'd1, 5, 32'hC3C3_9999, 1);
    drain();

    // Abort mid-shift: no done, then a fresh op completes.
    start_op(1, 1, 2'd2, 20, 32'h8765_4321, 0);
    @(negedge clk);
    b1.abort = 1; b8.abort = 1;
    @(negedge clk);
    b1.abort = 0; b8.abort = 0;
    chk("abort_busy1", 32'(b1.busy), 0); chk("abort_done1", 32'(b1.done), 0);
    chk("abort_busy8", 32'(b8.busy), 0); chk("abort_done8", 32'(b8.done), 0);
    repeat (40) @(negedge clk);
    start_op(1, 1, 2'd3, 9, 32'h0F0F_1234, 1); drain();

    // Asynchronous reset mid-shift clears outputs before any clock edge.
    start_op(1, 1, 2'd0, 25, 32'hFFFF_FFFF, 1);
    repeat (2) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_busy1", 32'(b1.busy), 0);  chk("arst_done1", 32'(b1.done), 0);
    chk("arst_result1", b1.result, 0);   chk("arst_busy8", 32'(b8.busy), 0);
    chk("arst_done8", 32'(b8.done), 0);  chk("arst_result8", b8.result, 0);
    q1.delete(); q8.delete();
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    start_op(1, 1, 2'd2, 13, 32'h9000_0001, 1); drain();

    for (int i = 0; i < 1000; i++) begin
      start_op(1, 1, 2'd0, 2, $urandom, 1); drain();
    end
    for (int i = 0; i < 300; i++) begin
      start_op(1, 1, 2'($urandom_range(0, 3)), int'($urandom_range(0, 31)), $urandom, 1);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got running want finished");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
